// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO burst reader and its output buffer.
package fifo_rd_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 8;
    localparam int unsigned BUF_DEPTH  = 2;
    localparam int unsigned OCC_W      = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_e;

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry output buffer: the head drives the stream, the tail absorbs the in-flight FIFO read.
module fifo_skid_buf2
    import fifo_rd_pkg::*;
#(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic [OCC_W-1:0] occ_o
);

    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_pop;

    assign do_pop = pop_i && (occ_q != '0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push_i, do_pop})
            2'b10: begin
                if (occ_q == '0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                occ_d = occ_q + 1'b1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 1'b1;
            end
            2'b11: begin
                // Occupancy unchanged; new entry lands wherever the pop left room.
                if (occ_q == OCC_W'(1)) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign valid_o = (occ_q != '0);
    assign data_o  = head_q;
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller for the 128x8 sync FIFO: pops cmd_len bytes and streams them with last.
// Define FIFO_BURST_READER_PARITY_EN to add out_parity (XOR of out_data) carried with each byte.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              fifo_empty,
    output logic              fifo_rdEn,
    input  logic [DATA_W-1:0] fifo_rdData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef FIFO_BURST_READER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

`ifdef FIFO_BURST_READER_PARITY_EN
    localparam int unsigned PayW = DATA_W + 2;
`else
    localparam int unsigned PayW = DATA_W + 1;
`endif

    rd_state_e        state_q, state_d;
    logic [LEN_W:0]   remaining_q, remaining_d;
    logic [LEN_W:0]   issued_q, issued_d;
    logic [LEN_W:0]   written_q, written_d;
    logic             inflight_q;
    logic             done_q, done_d;
    logic             buf_pop;
    logic             push_last;
    logic [PayW-1:0]  push_pay, head_pay;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] used;

    assign buf_pop   = out_valid && out_ready;
    assign push_last = ((written_q + 1'b1) == remaining_q);
    // A slot freed by this cycle's handshake can be re-credited immediately for full throughput.
    assign used      = occ - OCC_W'(buf_pop) + OCC_W'(inflight_q);

`ifdef FIFO_BURST_READER_PARITY_EN
    assign push_pay   = {^fifo_rdData, push_last, fifo_rdData};
    assign out_parity = head_pay[DATA_W+1];
`else
    assign push_pay   = {push_last, fifo_rdData};
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        written_d   = written_q;
        done_d      = 1'b0;
        fifo_rdEn   = 1'b0;
        if (inflight_q) begin
            written_d = written_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    remaining_d = (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
                    issued_d    = '0;
                    written_d   = '0;
                    state_d     = READ;
                end
            end
            READ: begin
                fifo_rdEn = !fifo_empty && (issued_q < remaining_q) &&
                            (used < OCC_W'(BUF_DEPTH));
                if (fifo_rdEn) begin
                    issued_d = issued_q + 1'b1;
                end
                if (issued_q == remaining_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last-byte handshake empties the buffer with nothing left in flight.
                if (buf_pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            issued_q    <= '0;
            written_q   <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            written_q   <= written_d;
            inflight_q  <= fifo_rdEn;
            done_q      <= done_d;
        end
    end

    fifo_skid_buf2 #(
        .Width (PayW)
    ) u_buf (
        .clk_i   (clk),
        .rst_ni  (rst_),
        .push_i  (inflight_q),
        .data_i  (push_pay),
        .pop_i   (buf_pop),
        .valid_o (out_valid),
        .data_o  (head_pay),
        .occ_o   (occ)
    );

    assign out_data  = head_pay[DATA_W-1:0];
    assign out_last  = head_pay[DATA_W];
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the team's 128x8 synchronous FIFO. It accepts a burst command (byte count), pops exactly that many bytes from the FIFO read port, and presents them on a valid/ready byte stream, with last flagged on the final byte. It absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so full throughput is 1 byte/cycle with no data loss under downstream backpressure.

Parameters:
DATA_W, 8, byte width; must match the FIFO data width.
LEN_W, 8, width of the burst length field; cmd_len==0 encodes 2**LEN_W bytes.

Ports:
clk  in  1  single clock, rising edge.
rst_  in  1  synchronous active-low reset, sampled on posedge clk.
cmd_valid  in  1  burst command valid.
cmd_ready  out  1  high in IDLE only.
cmd_len  in  LEN_W  byte count; 0 means 2**LEN_W.
fifo_empty  in  1  FIFO empty flag.
fifo_rdEn  out  1  FIFO pop request.
fifo_rdData  in  DATA_W  FIFO read data, valid the cycle after an accepted pop.
out_valid  out  1  output byte valid.
out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
out_data  out  DATA_W  output byte.
out_last  out  1  final byte of the burst, qualified by out_valid.
busy  out  1  high from command accept until the last byte is handshaken.
done  out  1  one-cycle pulse the cycle after the last-byte handshake.

Behaviour:
- Reset (rst_==0 at posedge): state=IDLE, remaining=0, inflight=0, buffer empty. Outputs: out_valid=0, out_data=0, out_last=0, fifo_rdEn=0, busy=0, done=0, cmd_ready=1.
- Reset mid-burst discards the count, the in-flight read and the buffered bytes. A byte popped from the FIFO is lost; that is acceptable.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch remaining = cmd_len (0 maps to 2**LEN_W, held in LEN_W+1 bits), set issued=0, and go to READ.
  - READ: issue pops until issued==remaining, then go to DRAIN.
  - DRAIN: wait until the buffer is empty and inflight==0, then go to IDLE and pulse done.
- fifo_rdEn is combinational and asserted only when all of these hold:
  - state==READ;
  - !fifo_empty;
  - issued < remaining;
  - (buffer occupancy + inflight) < 2.
  - fifo_rdEn is never asserted while fifo_empty==1.
- inflight is a 1-bit register set by fifo_rdEn. In the following cycle, fifo_rdData is written into the buffer tail and tagged last if it is byte number remaining.
- Buffer:
  - 2-entry FIFO with head driving out_data/out_last and out_valid = occupancy!=0.
  - Write and handshake in the same cycle keep occupancy constant.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Throughput: with out_ready held at 1 and the FIFO non-empty, one byte per cycle. The first out_valid appears 2 cycles after the command is accepted.
- FIFO goes empty mid-burst: pops pause and resume when !fifo_empty, with no byte skipped or duplicated.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- done rises the cycle after the out_last handshake and lasts one cycle. cmd_ready returns to 1 in that same cycle.
- Width rule: issued and the beat counter are LEN_W+1 bits; they do not wrap within a burst.

Optional Feature:
FIFO_BURST_READER_PARITY_EN
- Defined: adds output port out_parity (1 bit) = XOR of out_data. It is carried through the buffer alongside the data and is 0 on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_rd_pkg:
  - state enum {IDLE, READ, DRAIN};
  - DATA_W and LEN_W defaults;
  - a localparam BUF_DEPTH=2.
- One natural sub-module: fifo_skid_buf2, the 2-entry data+last(+parity) buffer with push/pop/occupancy. The top level holds the FSM and counters.

Test Plan:
1. FIFO preloaded with 0x10..0x13, cmd_len=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on consecutive cycles; last on 0x13; done 1 cycle later; fifo_rdEn asserted exactly 4 cycles.
2. cmd_len=3, out_ready toggling 1,0,0,1,... -> no loss or duplication; data stable while stalled; occupancy never exceeds 2; only 3 pops.
3. FIFO empty at command accept, bytes 0xA5,0x5A written 5 cycles later, cmd_len=2 -> fifo_rdEn stays 0 while empty; output is 0xA5 then 0x5A with last on 0x5A.
4. cmd_len=0 with 256 bytes available over refills -> exactly 256 bytes; last on byte 256; counters do not wrap.
5. rst_=0 for one cycle mid-burst after 2 of 5 bytes -> next cycle out_valid=0, busy=0, cmd_ready=1; a new cmd_len=1 completes normally.
6. PARITY_EN build, bytes 0x07,0x03 -> out_parity 1,0; non-PARITY build passes scenario 1 unchanged.
